dfsm_burst: RTL and testbench
=============================

# dfsm_burst

Parametrised successor to the single-beat data-flow sequencer. It streams `number_blocks` blocks from OCM through the burst master in multi-beat bursts, with credit-based flow control. It feeds a pipelined cipher engine in CTR or ECB mode and lands results in an internal output FIFO read by the AXI-slave side. It sits between the burst master, the AES engine and the register/readback logic.

## Interface
- `DATA_W`, default 128: block/beat width.
- `CNT_W`, default 16: width of `number_blocks` and of the block index.
- `BURST_LEN`, default 4: maximum beats per burst, power of two, 1..16.
- `IN_DEPTH`, default 16: input FIFO depth, power of two, ≥ `BURST_LEN`.
- `OUT_DEPTH`, default 16: output FIFO depth, power of two.
- `MAX_INFLIGHT`, default 8: engine pipeline depth bound, ≤ `OUT_DEPTH`.
- `clk  in  1`: single clock; all logic on rising edge.
- `reset_n  in  1`: asynchronous, active-low reset.
- `start  in  1`: level/pulse; sampled only in IDLE.
- `mode  in  1`: 0 = ECB (engine input = data), 1 = CTR (engine input = counter).
- `number_blocks  in  CNT_W`: block count, latched at start.
- `ctr_iv  in  DATA_W`: initial counter, latched at start.
- `init_master_txn  out  1`: one-cycle burst request pulse.
- `read_addr_index  out  32`: first block index of the burst.
- `burst_beats  out  5`: beats in this burst, 1..`BURST_LEN`.
- `bus_data_valid  in  1`: one beat valid on `ocm_data_out`.
- `ocm_data_out  in  DATA_W`: read beat.
- `read_done  in  1`: burst complete pulse.
- `eng_in_valid  out  1`, `eng_in_ready  in  1`, `eng_in_data  out  DATA_W`: engine input handshake.
- `eng_out_valid  in  1`, `eng_out_data  in  DATA_W`: engine result. No backpressure; in order.
- `output_fifo_read_en  in  1`, `output_fifo_read_data  out  DATA_W`, `output_fifo_empty  out  1`, `output_fifo_count  out  log2(OUT_DEPTH)+1`.
- `busy  out  1`, `out_ready  out  1`, `overrun_err  out  1`.

## Operation
- States: IDLE, ISSUE, WAIT_BURST, RUN_TAIL, DONE.
- IDLE:
  - On `start`, latch `number_blocks`, `ctr_iv` and `mode`; clear all counters.
  - If `number_blocks == 0`, go to DONE; otherwise go to ISSUE.
- ISSUE:
  - `beats = min(BURST_LEN, remaining)`.
  - Pulse `init_master_txn` only when input FIFO free slots ≥ `beats`. Otherwise stall in ISSUE.
  - `read_addr_index` = blocks requested so far. Go to WAIT_BURST.
- WAIT_BURST:
  - Each `bus_data_valid` pushes a beat into the input FIFO.
  - On `read_done`: if `remaining > 0`, go to ISSUE; otherwise go to RUN_TAIL.
- Engine feed runs concurrently in ISSUE, WAIT_BURST and RUN_TAIL.
  - Gate: `eng_in_valid` only if `inflight + output_fifo_count < OUT_DEPTH` and `inflight < MAX_INFLIGHT`.
  - ECB: also requires input FIFO non-empty; a handshake pops it.
  - CTR: also requires `ctr_issued < number_blocks` and `input_count > inflight`. `eng_in_data = ctr_iv + ctr_issued`, modulo 2^DATA_W; the full-width add wraps silently.
- Result path:
  - `eng_out_valid` pushes to the output FIFO: `eng_out_data` in ECB, `eng_out_data ^ input_head` in CTR (CTR pops the input head).
  - `inflight` increments on handshake, decrements on `eng_out_valid`; both in the same cycle leave it unchanged.
- RUN_TAIL → DONE when every block has been written to the output FIFO.
- DONE:
  - `out_ready` = 1 while in DONE.
  - Return to IDLE when `start == 0` and the output FIFO is empty.
- Errors:
  - A `bus_data_valid` beyond the requested beat count sets `overrun_err` and the beat is dropped.
  - `overrun_err` is sticky until reset or the next accepted start.
- Output FIFO:
  - A read on empty is ignored and data holds.
  - Read and write in the same cycle at full is legal; the count is unchanged.

## Timing
- Reset values:
  - All outputs 0, except `output_fifo_empty` = 1.
  - FSM in IDLE; both FIFOs empty.
  - Asserting `reset_n` mid-operation aborts immediately; in-flight beats and engine results arriving after reset are ignored.
- `start` sampled at edge N → `init_master_txn` high in cycle N+1, provided the input FIFO has room.
- Bus beat → input FIFO count visible the next cycle. Engine handshake is combinational on `eng_in_ready`.
- `eng_out_valid` at edge M → `output_fifo_empty` falls at M+1.
- `output_fifo_read_data` is first-word-fall-through: valid whenever not empty, advances the cycle after `read_en`.
- `busy` is high from the cycle after start acceptance until DONE is entered.
- `read_done` and the last `bus_data_valid` may coincide; the beat is still taken.

## Structure
- Package `dfsm_pkg`: state enum, `dfsm_mode_e` {ECB, CTR}, and the `min` helper function.
- Sub-module `dfsm_fifo`: parametrised sync FWFT FIFO with DATA_W/DEPTH, count and full/empty. Instantiated twice (input and output).

## Test plan
- CTR, `number_blocks`=3, BURST_LEN=4, `ctr_iv`=10, zero-latency engine model:
  - Response: one burst with `burst_beats`=3 and index 0; engine sees counters 10, 11, 12.
  - Output = data XOR keystream; `out_ready` rises.
- ECB, `number_blocks`=9, BURST_LEN=4:
  - Response: bursts of 4, 4, 1 at indices 0, 4, 8.
  - 9 words appear in order in the output FIFO.
- Output FIFO never read, OUT_DEPTH=4, `number_blocks`=8:
  - `eng_in_valid` stops once `inflight + count` reaches 4; no push is lost.
  - Draining the FIFO resumes processing.
- `ctr_iv`=2^128−1, 2 blocks: engine counters are all-ones, then 0.
- `number_blocks`=0: no `init_master_txn` pulse; `out_ready`=1 one cycle after start.
- Overrun and reset:
  - An extra `bus_data_valid` beat after burst completion sets `overrun_err`; output count is unchanged.
  - `reset_n` low mid-burst returns the block to IDLE with all outputs at reset values.

Source files
------------

// File: rtl/dfsm_pkg.sv
// dfsm_pkg: shared state/mode types and helpers for the burst data-flow sequencer
package dfsm_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BURST, RUN_TAIL, DONE} dfsm_state_e;
  typedef enum logic {ECB, CTR} dfsm_mode_e;
  function automatic int unsigned min(input int unsigned a, input int unsigned b);
    return a < b ? a : b;
  endfunction
endpackage

// File: rtl/dfsm_fifo.sv
// dfsm_fifo: synchronous first-word-fall-through FIFO with occupancy count
module dfsm_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/dfsm_burst.sv
// dfsm_burst: burst-read data-flow sequencer feeding a pipelined ECB/CTR cipher engine
module dfsm_burst
  import dfsm_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CNT_W = 16,
  parameter int BURST_LEN = 4,
  parameter int IN_DEPTH = 16,
  parameter int OUT_DEPTH = 16,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       mode,
  input  logic [CNT_W-1:0]           number_blocks,
  input  logic [DATA_W-1:0]          ctr_iv,
  output logic                       init_master_txn,
  output logic [31:0]                read_addr_index,
  output logic [4:0]                 burst_beats,
  input  logic                       bus_data_valid,
  input  logic [DATA_W-1:0]          ocm_data_out,
  input  logic                       read_done,
  output logic                       eng_in_valid,
  input  logic                       eng_in_ready,
  output logic [DATA_W-1:0]          eng_in_data,
  input  logic                       eng_out_valid,
  input  logic [DATA_W-1:0]          eng_out_data,
  input  logic                       output_fifo_read_en,
  output logic [DATA_W-1:0]          output_fifo_read_data,
  output logic                       output_fifo_empty,
  output logic [$clog2(OUT_DEPTH):0] output_fifo_count,
  output logic                       busy,
  output logic                       out_ready,
  output logic                       overrun_err
);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int FW = $clog2(MAX_INFLIGHT + 1);
  dfsm_state_e state;
  dfsm_mode_e mode_q;
  logic [CNT_W-1:0] nblk_q, req_cnt, ctr_issued, out_written, remaining;
  logic [DATA_W-1:0] iv_q, in_head;
  logic [4:0] beats, beats_exp, beats_rcv;
  logic [FW-1:0] inflight;
  logic [IAW:0] in_count;
  logic [31:0] in_free;
  logic in_empty, in_full, out_full;
  logic feed_st, cap_ok, hs, res_take, accept, in_pop;
  assign remaining = nblk_q - req_cnt;
  assign beats = 5'(min(BURST_LEN, 32'(remaining)));
  assign in_free = 32'(IN_DEPTH) - 32'(in_count);
  assign init_master_txn = state == ISSUE && !in_full && in_free >= 32'(beats);
  assign read_addr_index = 32'(req_cnt);
  assign burst_beats = state == ISSUE ? beats : '0;
  assign feed_st = state == ISSUE || state == WAIT_BURST || state == RUN_TAIL;
  assign cap_ok = !out_full && 32'(inflight) + 32'(output_fifo_count) < 32'(OUT_DEPTH)
                  && 32'(inflight) < 32'(MAX_INFLIGHT);
  assign eng_in_valid = feed_st && cap_ok
                        && (mode_q == CTR ? (ctr_issued < nblk_q && 32'(in_count) > 32'(inflight)) : !in_empty);
  assign eng_in_data = mode_q == CTR ? iv_q + DATA_W'(ctr_issued) : in_head;
  assign hs = eng_in_valid && eng_in_ready;
  assign res_take = eng_out_valid && feed_st;
  assign accept = bus_data_valid && state == WAIT_BURST && beats_rcv < beats_exp;
  assign in_pop = mode_q == CTR ? res_take : hs;
  dfsm_fifo #(.DATA_W(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (accept),
    .push_data (ocm_data_out),
    .pop       (in_pop),
    .pop_data  (in_head),
    .count     (in_count),
    .full      (in_full),
    .empty     (in_empty)
  );
  dfsm_fifo #(.DATA_W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (res_take),
    .push_data (mode_q == CTR ? eng_out_data ^ in_head : eng_out_data),
    .pop       (output_fifo_read_en),
    .pop_data  (output_fifo_read_data),
    .count     (output_fifo_count),
    .full      (out_full),
    .empty     (output_fifo_empty)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      mode_q <= ECB;
      nblk_q <= '0;
      iv_q <= '0;
      req_cnt <= '0;
      ctr_issued <= '0;
      out_written <= '0;
      beats_exp <= '0;
      beats_rcv <= '0;
      inflight <= '0;
      busy <= 1'b0;
      out_ready <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (hs) ctr_issued <= ctr_issued + CNT_W'(1);
      if (res_take) out_written <= out_written + CNT_W'(1);
      inflight <= inflight + FW'(hs) - FW'(res_take);
      if (accept) beats_rcv <= beats_rcv + 5'd1;
      if (bus_data_valid && !accept && state != IDLE) overrun_err <= 1'b1;
      case (state)
        IDLE:
          if (start) begin
            mode_q <= dfsm_mode_e'(mode);
            nblk_q <= number_blocks;
            iv_q <= ctr_iv;
            req_cnt <= '0;
            ctr_issued <= '0;
            out_written <= '0;
            beats_exp <= '0;
            beats_rcv <= '0;
            inflight <= '0;
            overrun_err <= 1'b0;
            busy <= number_blocks != '0;
            out_ready <= number_blocks == '0;
            state <= number_blocks == '0 ? DONE : ISSUE;
          end
        ISSUE:
          if (init_master_txn) begin
            req_cnt <= req_cnt + CNT_W'(beats);
            beats_exp <= beats;
            beats_rcv <= '0;
            state <= WAIT_BURST;
          end
        WAIT_BURST:
          if (read_done) state <= req_cnt != nblk_q ? ISSUE : RUN_TAIL;
        RUN_TAIL:
          if (out_written == nblk_q) begin
            busy <= 1'b0;
            out_ready <= 1'b1;
            state <= DONE;
          end
        DONE:
          if (!start && output_fifo_empty) begin
            out_ready <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dfsm_burst.sv
// tb_dfsm_burst: directed checks of burst sequencing, engine feed, output FIFO and error handling
module tb_dfsm_burst;
  localparam int DW = 128;
  localparam int CW = 16;
  localparam logic [DW-1:0] KEY = {4{32'h5A5A_5A5A}};
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic [CW-1:0] number_blocks = '0;
  logic [DW-1:0] ctr_iv = '0;
  logic [DW-1:0] ocm_data_out = '0;
  logic bus_data_valid = 1'b0;
  logic read_done = 1'b0;
  logic eng_in_ready = 1'b1;
  logic output_fifo_read_en = 1'b0;
  logic init_master_txn, eng_in_valid, eng_out_valid, output_fifo_empty, busy, out_ready, overrun_err;
  logic [31:0] read_addr_index;
  logic [4:0] burst_beats;
  logic [DW-1:0] eng_in_data, eng_out_data, output_fifo_read_data;
  logic [2:0] output_fifo_count;
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] br_idx [8];
  logic [4:0] br_beats [8];
  logic [DW-1:0] eng_log [16];
  logic [DW-1:0] got [16];
  int n_br = 0;
  int n_eng = 0;
  int n_got = 0;
  int pend_left = 0;
  logic [31:0] pend_idx = '0;
  logic saw_ready = 1'b0;
  logic inject = 1'b0;
  assign eng_out_valid = eng_in_valid && eng_in_ready;
  assign eng_out_data = eng_in_data ^ KEY;
  always #5 clk = ~clk;
  dfsm_burst #(
    .DATA_W(DW), .CNT_W(CW), .BURST_LEN(4), .IN_DEPTH(16), .OUT_DEPTH(4), .MAX_INFLIGHT(4)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .start                 (start),
    .mode                  (mode),
    .number_blocks         (number_blocks),
    .ctr_iv                (ctr_iv),
    .init_master_txn       (init_master_txn),
    .read_addr_index       (read_addr_index),
    .burst_beats           (burst_beats),
    .bus_data_valid        (bus_data_valid),
    .ocm_data_out          (ocm_data_out),
    .read_done             (read_done),
    .eng_in_valid          (eng_in_valid),
    .eng_in_ready          (eng_in_ready),
    .eng_in_data           (eng_in_data),
    .eng_out_valid         (eng_out_valid),
    .eng_out_data          (eng_out_data),
    .output_fifo_read_en   (output_fifo_read_en),
    .output_fifo_read_data (output_fifo_read_data),
    .output_fifo_empty     (output_fifo_empty),
    .output_fifo_count     (output_fifo_count),
    .busy                  (busy),
    .out_ready             (out_ready),
    .overrun_err           (overrun_err)
  );
  function automatic logic [DW-1:0] ocm_word(input int i);
    return {4{32'hC0DE_0000 | 32'(i)}};
  endfunction
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask
  task automatic step();
    @(negedge clk);
    if (eng_in_valid && eng_in_ready && n_eng < 16) begin
      eng_log[n_eng] = eng_in_data;
      n_eng++;
    end
    if (init_master_txn && n_br < 8) begin
      br_idx[n_br] = read_addr_index;
      br_beats[n_br] = burst_beats;
      n_br++;
      pend_idx = read_addr_index;
      pend_left = int'(burst_beats);
    end
    if (output_fifo_read_en && !output_fifo_empty && n_got < 16) begin
      got[n_got] = output_fifo_read_data;
      n_got++;
    end
    if (out_ready) saw_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_data_valid = inject;
    read_done = 1'b0;
    inject = 1'b0;
    if (pend_left > 0) begin
      bus_data_valid = 1'b1;
      ocm_data_out = ocm_word(int'(pend_idx));
      pend_idx++;
      pend_left--;
      read_done = pend_left == 0;
    end
  endtask
  task automatic go(input logic m, input int nb, input logic [DW-1:0] iv);
    n_br = 0;
    n_eng = 0;
    n_got = 0;
    saw_ready = 1'b0;
    mode = m;
    number_blocks = CW'(nb);
    ctr_iv = iv;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic drain(input int n, input string tag);
    for (int i = 0; i < 100 && n_got < n; i++) step();
    chk({tag, "_drained"}, DW'(n_got), DW'(n));
  endtask
  task automatic reset_check(input string t);
    chk({t, "_init"}, DW'(init_master_txn), 0);
    chk({t, "_addr"}, DW'(read_addr_index), 0);
    chk({t, "_beats"}, DW'(burst_beats), 0);
    chk({t, "_eng_v"}, DW'(eng_in_valid), 0);
    chk({t, "_eng_d"}, eng_in_data, 0);
    chk({t, "_rdata"}, output_fifo_read_data, 0);
    chk({t, "_empty"}, DW'(output_fifo_empty), 1);
    chk({t, "_count"}, DW'(output_fifo_count), 0);
    chk({t, "_busy"}, DW'(busy), 0);
    chk({t, "_ready"}, DW'(out_ready), 0);
    chk({t, "_ovr"}, DW'(overrun_err), 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) step();
    reset_check("rst");
    reset_n = 1'b1;
    step();
    go(1'b1, 3, 10);
    step();
    chk("ctr_init_lat", DW'(n_br), 1);
    chk("ctr_busy", DW'(busy), 1);
    for (int i = 0; i < 100 && !out_ready; i++) step();
    chk("ctr_out_ready", DW'(out_ready), 1);
    chk("ctr_fifo_cnt", DW'(output_fifo_count), 3);
    chk("ctr_nburst", DW'(n_br), 1);
    chk("ctr_burst_idx", DW'(br_idx[0]), 0);
    chk("ctr_burst_beats", DW'(br_beats[0]), 3);
    for (int j = 0; j < 3; j++) chk("ctr_eng_in", eng_log[j], DW'(10 + j));
    output_fifo_read_en = 1'b1;
    drain(3, "ctr");
    output_fifo_read_en = 1'b0;
    chk("ctr_out0", got[0], 128'h9A845A5A_9A845A5A_9A845A5A_9A845A50);
    for (int j = 1; j < 3; j++) chk("ctr_out", got[j], DW'(10 + j) ^ KEY ^ ocm_word(j));
    repeat (3) step();
    chk("ctr_idle_ready", DW'(out_ready), 0);
    output_fifo_read_en = 1'b1;
    go(1'b0, 9, 0);
    drain(9, "ecb");
    repeat (3) step();
    output_fifo_read_en = 1'b0;
    chk("ecb_nburst", DW'(n_br), 3);
    for (int j = 0; j < 3; j++) chk("ecb_burst_idx", DW'(br_idx[j]), DW'(4 * j));
    chk("ecb_beats0", DW'(br_beats[0]), 4);
    chk("ecb_beats1", DW'(br_beats[1]), 4);
    chk("ecb_beats2", DW'(br_beats[2]), 1);
    for (int j = 0; j < 9; j++) chk("ecb_out", got[j], ocm_word(j) ^ KEY);
    chk("ecb_saw_ready", DW'(saw_ready), 1);
    go(1'b0, 8, 0);
    repeat (60) step();
    chk("bp_count", DW'(output_fifo_count), 4);
    chk("bp_eng_stall", DW'(eng_in_valid), 0);
    chk("bp_handshakes", DW'(n_eng), 4);
    chk("bp_busy", DW'(busy), 1);
    chk("bp_nburst", DW'(n_br), 2);
    output_fifo_read_en = 1'b1;
    drain(8, "bp");
    repeat (3) step();
    for (int j = 0; j < 8; j++) chk("bp_out", got[j], ocm_word(j) ^ KEY);
    chk("bp_saw_ready", DW'(saw_ready), 1);
    go(1'b1, 2, '1);
    drain(2, "wrap");
    repeat (3) step();
    output_fifo_read_en = 1'b0;
    chk("wrap_ctr0", eng_log[0], '1);
    chk("wrap_ctr1", eng_log[1], 0);
    chk("wrap_out0", got[0], ~KEY ^ ocm_word(0));
    chk("wrap_out1", got[1], KEY ^ ocm_word(1));
    go(1'b0, 0, 0);
    chk("zero_ready", DW'(out_ready), 1);
    chk("zero_busy", DW'(busy), 0);
    repeat (4) step();
    chk("zero_nburst", DW'(n_br), 0);
    chk("zero_idle", DW'(out_ready), 0);
    go(1'b0, 2, 0);
    for (int i = 0; i < 100 && !out_ready; i++) step();
    chk("ovr_done", DW'(out_ready), 1);
    chk("ovr_pre", DW'(overrun_err), 0);
    inject = 1'b1;
    step();
    step();
    chk("ovr_set", DW'(overrun_err), 1);
    chk("ovr_count", DW'(output_fifo_count), 2);
    output_fifo_read_en = 1'b1;
    drain(2, "ovr");
    output_fifo_read_en = 1'b0;
    repeat (3) step();
    chk("ovr_sticky", DW'(overrun_err), 1);
    go(1'b0, 8, 0);
    chk("ovr_clear", DW'(overrun_err), 0);
    for (int i = 0; i < 20 && n_br < 1; i++) step();
    chk("abort_issued", DW'(n_br), 1);
    step();
    reset_n = 1'b0;
    #1;
    reset_check("abort");
    step();
    reset_n = 1'b1;
    repeat (4) step();
    reset_check("post");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
